// File: rtl/btcoin_pwr_seq.sv
// -----------------------------------------------------------------------------
// btcoin_pwr_seq
//
// Power-management sequencer placed in front of the bitcoin hashing core.
// Power-down order: isolate, save retention state, staggered domain sleep.
// Power-up runs the reverse. Upstream data_valid is gated whenever the core
// is not fully active.
//
// Ports
//   clk                clock, all state on rising edge
//   reset              asynchronous, active-low reset
//   lp_req             level request: 1 = low power, 0 = active
//   data_valid_in      upstream valid qualifier
//   power_ack_signals  [NUM_SLEEP-1:0] sleep acks,
//                      [NUM_SLEEP+1:NUM_SLEEP] isolation acks,
//                      [NUM_SLEEP+2] retention ack
//   data_valid         gated valid to the core (combinational)
//   lp_enable          low-power indicator (registered)
//   sleep_signals      per-domain sleep, 1 = off (registered)
//   isolation_signals  isolation enables (registered)
//   retention_signals  [0] save, [1] restore (registered)
//   pwr_state          current FSM state
//   pwr_busy           1 in any state other than ACTIVE
//   pwr_err            sticky ack-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module btcoin_pwr_seq #(
    parameter int NUM_SLEEP   = 18,
    parameter int STAGGER     = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 lp_req,
    input  logic                 data_valid_in,
    input  logic [NUM_SLEEP+2:0] power_ack_signals,
    output logic                 data_valid,
    output logic                 lp_enable,
    output logic [NUM_SLEEP-1:0] sleep_signals,
    output logic [1:0]           isolation_signals,
    output logic [1:0]           retention_signals,
    output logic [2:0]           pwr_state,
    output logic                 pwr_busy,
    output logic                 pwr_err
);

    typedef enum logic [2:0] {
        ACTIVE    = 3'd0,
        ISO_ON    = 3'd1,
        SAVE      = 3'd2,
        SLEEP_ON  = 3'd3,
        OFF       = 3'd4,
        SLEEP_OFF = 3'd5,
        RESTORE   = 3'd6,
        ISO_OFF   = 3'd7
    } state_e;

    localparam int IDX_W = $clog2(NUM_SLEEP + 1);
    localparam int STG_W = $clog2(STAGGER + 1);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IDX_DONE = IDX_W'(NUM_SLEEP);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_SLEEP - 1);
    localparam logic [STG_W-1:0] STG_LAST = STG_W'(STAGGER - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(ACK_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    logic [NUM_SLEEP-1:0] ack_sleep;
    logic [1:0]           ack_iso;
    logic                 ack_ret;

    assign ack_sleep = power_ack_signals[NUM_SLEEP-1:0];
    assign ack_iso   = power_ack_signals[NUM_SLEEP+1:NUM_SLEEP];
    assign ack_ret   = power_ack_signals[NUM_SLEEP+2];

    state_e               state_q, state_d;
    logic [NUM_SLEEP-1:0] sleep_q, sleep_d;
    logic [1:0]           iso_q, iso_d;
    logic [1:0]           ret_q, ret_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic [IDX_W-1:0]     idx_q, idx_d;     // sleep bits changed so far
    logic [STG_W-1:0]     stg_q, stg_d;     // cycles since last sleep-bit change
    logic [TMO_W-1:0]     tmo_q, tmo_d;     // ack-wait cycles in current state
    logic                 phase_q, phase_d; // RESTORE: 0 = wait ack low, 1 = restore pulse
    logic                 waiting;          // this edge waited on an ack without exiting

    // NOTE: every variable gets a default before the case, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        sleep_d = sleep_q;
        iso_d   = iso_q;
        ret_d   = ret_q;
        idx_d   = idx_q;
        stg_d   = stg_q;
        tmo_d   = tmo_q;
        phase_d = phase_q;
        err_d   = err_q;
        waiting = 1'b0;

        unique case (state_q)
            ACTIVE: begin
                sleep_d = '0;
                iso_d   = 2'b00;
                ret_d   = 2'b00;
                if (lp_req) begin
                    state_d = ISO_ON;
                    iso_d   = 2'b11;
                end
            end
            ISO_ON: begin
                if (ack_iso == 2'b11) begin
                    state_d  = SAVE;
                    ret_d[0] = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            SAVE: begin
                if (ack_ret) begin
                    state_d    = SLEEP_ON;
                    ret_d[0]   = 1'b0;
                    sleep_d[0] = 1'b1;
                    idx_d      = IDX_W'(1);
                    stg_d      = '0;
                end else begin
                    waiting = 1'b1;
                end
            end
            SLEEP_ON: begin
                // Staggering phase does not count toward the ack timeout.
                if (idx_q != IDX_DONE) begin
                    if (stg_q == STG_LAST) begin
                        sleep_d[idx_q] = 1'b1;
                        idx_d          = idx_q + 1'b1;
                        stg_d          = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end else if (&ack_sleep) begin
                    state_d = OFF;
                end else begin
                    waiting = 1'b1;
                end
            end
            OFF: begin
                sleep_d = '1;
                iso_d   = 2'b11;
                if (!lp_req) begin
                    state_d          = SLEEP_OFF;
                    sleep_d[IDX_TOP] = 1'b0;
                    idx_d            = IDX_W'(1);
                    stg_d            = '0;
                end
            end
            SLEEP_OFF: begin
                // Domains wake in reverse order: top bit first.
                if (idx_q != IDX_DONE) begin
                    if (stg_q == STG_LAST) begin
                        sleep_d[IDX_TOP - idx_q] = 1'b0;
                        idx_d                    = idx_q + 1'b1;
                        stg_d                    = '0;
                    end else begin
                        stg_d = stg_q + 1'b1;
                    end
                end else if (ack_sleep == '0) begin
                    state_d = RESTORE;
                    phase_d = 1'b0;
                end else begin
                    waiting = 1'b1;
                end
            end
            RESTORE: begin
                // A stale save ack must drop before the restore pulse starts,
                // otherwise it would be mistaken for the restore ack.
                if (!phase_q) begin
                    if (!ack_ret) begin
                        phase_d  = 1'b1;
                        ret_d[1] = 1'b1;
                    end else begin
                        waiting = 1'b1;
                    end
                end else if (ack_ret) begin
                    phase_d  = 1'b0;
                    ret_d[1] = 1'b0;
                    state_d  = ISO_OFF;
                    iso_d    = 2'b00;
                end else begin
                    waiting = 1'b1;
                end
            end
            ISO_OFF: begin
                if (ack_iso == 2'b00) begin
                    state_d = ACTIVE;
                end else begin
                    waiting = 1'b1;
                end
            end
        endcase

        // Timeout counter restarts on each state entry and saturates.
        if (state_d != state_q) begin
            tmo_d = '0;
        end else if (waiting && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TMO_LAST) begin
                err_d = 1'b1;
            end
        end

        busy_d = (state_d != ACTIVE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ACTIVE;
            sleep_q <= '0;
            iso_q   <= 2'b00;
            ret_q   <= 2'b00;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            stg_q   <= '0;
            tmo_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sleep_q <= sleep_d;
            iso_q   <= iso_d;
            ret_q   <= ret_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            stg_q   <= stg_d;
            tmo_q   <= tmo_d;
            phase_q <= phase_d;
        end
    end

    assign pwr_state         = state_q;
    assign sleep_signals     = sleep_q;
    assign isolation_signals = iso_q;
    assign retention_signals = ret_q;
    assign lp_enable         = busy_q;
    assign pwr_busy          = busy_q;
    assign pwr_err           = err_q;
    assign data_valid        = data_valid_in & (state_q == ACTIVE);

endmodule

// File: tb/tb_btcoin_pwr_seq.sv
// -----------------------------------------------------------------------------
// tb_btcoin_pwr_seq
//
// Scoreboard bench for btcoin_pwr_seq. Stimulus pushes the expected sequence
// of registered-output snapshots (plus cycle gap from the previous change);
// a monitor pops one entry each time the DUT's outputs change. A small ack
// model mirrors the DUT's control outputs back half a cycle later, with
// override knobs for stuck/partial acks.
// -----------------------------------------------------------------------------
module tb_btcoin_pwr_seq;

    localparam int NS = 18;

    typedef struct {
        logic [2:0]    st;
        logic [NS-1:0] sl;
        logic [1:0]    iso;
        logic [1:0]    ret;
        logic          err;
        int            gap;   // -1 = gap not checked
    } ev_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          lp_req = 1'b0;
    logic          data_valid_in = 1'b0;
    logic [NS-1:0] ack_sleep = '0;
    logic [1:0]    ack_iso = 2'b00;
    logic          ack_ret = 1'b0;
    logic          data_valid;
    logic          lp_enable;
    logic [NS-1:0] sleep_signals;
    logic [1:0]    isolation_signals;
    logic [1:0]    retention_signals;
    logic [2:0]    pwr_state;
    logic          pwr_busy;
    logic          pwr_err;

    logic          iso_force = 1'b0;
    logic [1:0]    iso_force_val = 2'b00;
    logic          ret_stuck = 1'b0;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    ev_t exp_q[$];

    btcoin_pwr_seq #(.NUM_SLEEP(NS), .STAGGER(2), .ACK_TIMEOUT(64)) dut (
        .clk               (clk),
        .reset             (reset),
        .lp_req            (lp_req),
        .data_valid_in     (data_valid_in),
        .power_ack_signals ({ack_ret, ack_iso, ack_sleep}),
        .data_valid        (data_valid),
        .lp_enable         (lp_enable),
        .sleep_signals     (sleep_signals),
        .isolation_signals (isolation_signals),
        .retention_signals (retention_signals),
        .pwr_state         (pwr_state),
        .pwr_busy          (pwr_busy),
        .pwr_err           (pwr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Core ack model: acks follow the controls, visible at the next rising edge.
    always @(negedge clk) begin
        ack_sleep <= sleep_signals;
        ack_iso   <= iso_force ? iso_force_val : isolation_signals;
        ack_ret   <= ret_stuck ? 1'b1 : (retention_signals[0] | retention_signals[1]);
    end

    // Random upstream valid, to exercise the gating.
    always @(posedge clk) begin
        #2 data_valid_in = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [NS-1:0] sl, input logic [1:0] iso,
                        input logic [1:0] ret, input logic err, input int gap);
        ev_t e;
        e.st = st; e.sl = sl; e.iso = iso; e.ret = ret; e.err = err; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Power-down: tmo=1 means ISO_ON acks are held bad long enough to time out.
    task automatic push_down(input logic tmo, input int nbits);
        logic [NS-1:0] sl;
        push(3'd1, '0, 2'b11, 2'b00, 1'b0, -1);
        if (tmo) begin
            push(3'd1, '0, 2'b11, 2'b00, 1'b1, 64);
            push(3'd2, '0, 2'b11, 2'b01, 1'b1, -1);
        end else begin
            push(3'd2, '0, 2'b11, 2'b01, 1'b0, 1);
        end
        push(3'd3, NS'(1), 2'b11, 2'b00, tmo, 1);
        for (int k = 1; k < nbits; k++) begin
            sl = (NS'(1) << (k + 1)) - NS'(1);
            push(3'd3, sl, 2'b11, 2'b00, tmo, 2);
        end
        if (nbits == NS) push(3'd4, '1, 2'b11, 2'b00, tmo, 1);
    endtask

    task automatic push_up(input logic err, input int first_gap, input int restore_gap);
        logic [NS-1:0] sl;
        push(3'd5, {1'b0, {(NS-1){1'b1}}}, 2'b11, 2'b00, err, first_gap);
        for (int k = NS - 2; k >= 0; k--) begin
            sl = (NS'(1) << k) - NS'(1);
            push(3'd5, sl, 2'b11, 2'b00, err, 2);
        end
        push(3'd6, '0, 2'b11, 2'b00, err, 1);
        push(3'd6, '0, 2'b11, 2'b10, err, restore_gap);
        push(3'd7, '0, 2'b00, 2'b00, err, 1);
        push(3'd0, '0, 2'b00, 2'b00, err, 1);
    endtask

    task automatic wait_state(input logic [2:0] s, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pwr_state == s) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_state_%0d: got state %0d, required %0d within %0d cycles",
                 s, pwr_state, s, budget);
    endtask

    // Monitor: one scoreboard pop per output change, plus data_valid gating.
    logic [27:0] prev_b = '0;
    int          last_cyc = 0;
    logic [2:0]  exp_state = 3'd0;

    always @(negedge clk) begin
        logic [27:0] act_b, req_b;
        ev_t e;
        act_b = {pwr_state, sleep_signals, isolation_signals, retention_signals,
                 pwr_busy, lp_enable, pwr_err};
        if (act_b !== prev_b) begin
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_change: got %0h, required no change %0h", act_b, prev_b);
            end else begin
                e = exp_q.pop_front();
                req_b = {e.st, e.sl, e.iso, e.ret, (e.st != 3'd0), (e.st != 3'd0), e.err};
                check("outputs", 32'(act_b), 32'(req_b));
                if (e.gap >= 0) check("gap_cycles", 32'(cyc - last_cyc), 32'(e.gap));
                exp_state = e.st;
            end
            prev_b   = act_b;
            last_cyc = cyc;
        end
        check("data_valid", 32'(data_valid), 32'(data_valid_in & (exp_state == 3'd0)));
    end

    initial begin
        #1;
        check("reset_outputs", 32'({pwr_state, sleep_signals, isolation_signals,
              retention_signals, pwr_busy, lp_enable, pwr_err}), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);

        // Nominal power-down and wake.
        push_down(1'b0, NS);
        push_up(1'b0, -1, 1);
        #2 lp_req = 1'b1;
        wait_state(3'd4, 100);
        repeat (3) @(posedge clk);
        #2 lp_req = 1'b0;
        wait_state(3'd0, 100);
        repeat (3) @(posedge clk);

        // Ack timeout in ISO_ON; error stays sticky through a full round trip.
        push_down(1'b1, NS);
        push_up(1'b1, -1, 1);
        #2 iso_force_val = 2'b01; iso_force = 1'b1; lp_req = 1'b1;
        repeat (70) @(posedge clk);
        #2 iso_force = 1'b0;
        wait_state(3'd4, 100);
        repeat (2) @(posedge clk);
        #2 lp_req = 1'b0;
        wait_state(3'd0, 100);
        repeat (2) @(posedge clk);
        push(3'd0, '0, 2'b00, 2'b00, 1'b0, -1);
        #2 reset = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (2) @(posedge clk);

        // lp_req dropped mid SLEEP_ON: completes to OFF, then wakes at once.
        push_down(1'b0, NS);
        push_up(1'b0, 1, 1);
        #2 lp_req = 1'b1;
        wait_state(3'd3, 20);
        repeat (5) @(posedge clk);
        #2 lp_req = 1'b0;
        wait_state(3'd0, 150);
        repeat (3) @(posedge clk);

        // Async reset with 9 sleep bits set.
        push_down(1'b0, 9);
        push(3'd0, '0, 2'b00, 2'b00, 1'b0, -1);
        #2 lp_req = 1'b1;
        begin : find_bit8
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (sleep_signals[8]) disable find_bit8;
            end
            n_cmp++; n_bad++;
            $display("FAIL wait_bit8: got sleep %0h, required bit 8 set", sleep_signals);
        end
        @(negedge clk); #1;
        reset = 1'b0; lp_req = 1'b0;
        #1;
        check("async_reset_outputs", 32'({pwr_state, sleep_signals, isolation_signals,
              retention_signals, pwr_busy, lp_enable, pwr_err}), 32'd0);
        check("async_reset_dv", 32'(data_valid), 32'(data_valid_in));
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);

        // Retention ack stuck high: restore pulse waits until ack seen low.
        push_down(1'b0, NS);
        push_up(1'b0, -1, -1);
        #2 ret_stuck = 1'b1; lp_req = 1'b1;
        wait_state(3'd4, 100);
        repeat (2) @(posedge clk);
        #2 lp_req = 1'b0;
        wait_state(3'd6, 100);
        repeat (10) @(posedge clk);
        #1 check("restore_held_off", 32'(retention_signals), 32'd0);
        #1 ret_stuck = 1'b0;
        wait_state(3'd0, 50);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++; n_bad++;
            $display("FAIL drain: got %0d pending events, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
